// File: rtl/inttofloat.sv
// inttofloat: iterative signed integer to IEEE-754 single-precision converter
module inttofloat #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] intin,
    output logic [31:0]      floatout,
    output logic             done,
    output logic             busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] NORM = 1'b1;
    localparam logic [7:0] EXP0 = 8'(127 + WIDTH - 1);
    logic [0:0]       state;
    logic             sign;
    logic             zero;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] abs_in;
    logic [7:0]       exp;
    logic [22:0]      frac;
    // operand magnitude (most negative value maps to 2^(WIDTH-1)) and significand bits below the hidden one
    always_comb begin
        abs_in = intin[WIDTH-1] ? -intin : intin;
        frac   = 23'(mag[WIDTH-2:0]) << (24 - WIDTH);
    end
    // latch on start, then shift left one bit per cycle until the hidden bit reaches the top
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            floatout <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            mag      <= '0;
            exp      <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                sign  <= intin[WIDTH-1];
                mag   <= abs_in;
                exp   <= EXP0;
                zero  <= (intin == '0);
                done  <= 1'b0;
                busy  <= 1'b1;
                state <= NORM;
            end
        end else if (zero) begin
            floatout <= '0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
        end else if (mag[WIDTH-1]) begin
            floatout <= {sign, exp, frac};
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
        end else begin
            mag <= mag << 1;
            exp <= exp - 8'd1;
        end
    end
endmodule

// File: tb/tb_inttofloat.sv
// tb_inttofloat: scoreboard bench for the iterative int16 to float32 converter
module tb_inttofloat;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] intin = '0;
    logic [31:0] floatout;
    logic        done;
    logic        busy;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        done_q = 1'b0;

    typedef struct {
        logic [31:0] f;
        int          lat;
        int          c0;
        logic [15:0] v;
    } exp_t;
    exp_t q[$];

    inttofloat #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .intin(intin),
        .floatout(floatout), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every rising done pops one expectation and checks value and latency
    always @(negedge clk) begin
        if (done && !done_q) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done floatout=%h at cycle %0d", floatout, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (floatout !== e.f) begin
                    errors++;
                    $display("FAIL value intin=%h got=%h want=%h", e.v, floatout, e.f);
                end
                checks++;
                if (cyc - e.c0 - 1 != e.lat) begin
                    errors++;
                    $display("FAIL latency intin=%h got=%0d want=%0d", e.v, cyc - e.c0 - 1, e.lat);
                end
            end
        end
        done_q = done;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic issue(input logic [15:0] v, input logic [31:0] f, input int lat, input bit expect_it);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        intin = v;
        e.f = f; e.lat = lat; e.c0 = cyc; e.v = v;
        if (expect_it) q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout waiting for done at cycle %0d", cyc);
        end
    endtask

    task automatic convert(input logic [15:0] v, input logic [31:0] f, input int lat);
        issue(v, f, lat, 1'b1);
        wait_done();
    endtask

    function automatic logic [31:0] ref_bits(input logic [15:0] v);
        logic [63:0] d;
        d = $realtobits($itor($signed(v)));
        return (v == 16'h0) ? 32'h0 : {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic int ref_lat(input logic [15:0] v);
        logic [63:0] d;
        d = $realtobits($itor($signed(v)));
        return (v == 16'h0) ? 1 : 16 - (int'(d[62:52]) - 1023);
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_floatout", floatout, 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        convert(16'h0001, 32'h3F80_0000, 16);
        convert(16'h8000, 32'hC700_0000, 1);
        convert(16'h7FFF, 32'h46FF_FE00, 2);
        convert(16'hFFFF, 32'hBF80_0000, 16);
        convert(16'h0000, 32'h0000_0000, 1);

        issue(16'h0001, 32'h0, 0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("abort_floatout", floatout, 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done), 32'h0);

        convert(16'd100, 32'h42C8_0000, 10);

        issue(16'h0001, 32'h3F80_0000, 16, 1'b1);
        repeat (2) @(negedge clk);
        issue(16'h0005, 32'h0, 0, 1'b0);
        wait_done();

        issue(16'h0005, 32'h40A0_0000, 14, 1'b1);
        check("restart_done_drops", 32'(done), 32'h0);
        check("restart_busy", 32'(busy), 32'h1);
        wait_done();

        @(negedge clk);
        start = 1'b1;
        intin = 16'h0000;
        begin
            exp_t e;
            e.f = 32'h0; e.lat = 1; e.c0 = cyc; e.v = 16'h0;
            q.push_back(e);
        end
        @(negedge clk);
        intin = 16'h0007;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("same_edge_start_ignored_busy", 32'(busy), 32'h0);
        check("same_edge_start_ignored_done", 32'(done), 32'h1);
        check("same_edge_start_ignored_val", floatout, 32'h0);

        convert(16'd100, 32'h42C8_0000, 10);
        for (int i = 0; i < 20; i++) begin
            intin = 16'($urandom);
            @(negedge clk);
            check("hold_floatout", floatout, 32'h42C8_0000);
            check("hold_done", 32'(done), 32'h1);
        end

        for (int i = 0; i < 2000; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (i % 7 == 0) v = v >> $urandom_range(15, 0);
            convert(v, ref_bits(v), ref_lat(v));
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
